ex_divider: RTL and testbench

Iterative RV64M divide/remainder unit in the EX stage, directly downstream of the forwarding unit: it consumes the forwarded rs1/rs2 operands and returns the quotient or remainder. The pipeline stalls on it for the duration of the operation.
- Covers DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- Uses a radix-2 restoring algorithm on operand magnitudes.
- Divide-by-zero and signed overflow are resolved in a single cycle.

---
 rtl/ex_divider_if.sv | 23 ++
 rtl/ex_divider.sv | 156 +++++++++++++++
 tb/tb_ex_divider.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ex_divider_if.sv
// Request/response bundle between the EX-stage issue logic and the
// iterative divide/remainder unit.
interface ex_divider_if;
  logic        DivValidInEx;
  logic        DivReadyOutEx;
  logic [63:0] Rs1DataIn;
  logic [63:0] Rs2DataIn;
  logic [2:0]  DivOpIn;
  logic        DivFlushIn;
  logic        DivBusyOut;
  logic [63:0] DivResultOut;
  logic        DivResultValidOut;

  modport master (
    output DivValidInEx, Rs1DataIn, Rs2DataIn, DivOpIn, DivFlushIn,
    input  DivReadyOutEx, DivBusyOut, DivResultOut, DivResultValidOut
  );

  modport slave (
    input  DivValidInEx, Rs1DataIn, Rs2DataIn, DivOpIn, DivFlushIn,
    output DivReadyOutEx, DivBusyOut, DivResultOut, DivResultValidOut
  );
endinterface

// File: rtl/ex_divider.sv
// Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU and W forms).
// Radix-2 restoring division on operand magnitudes, one bit per cycle;
// divide-by-zero and signed overflow bypass the iteration entirely.
module ex_divider (
  input  logic        clk,
  input  logic        rst,
  ex_divider_if.slave bus
);
  localparam int DATA_W = 64;
  localparam logic [DATA_W-1:0] MIN_D = 64'h8000_0000_0000_0000;
  localparam logic [DATA_W-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] quo, rem, b_mag, result_q, final_val;
  logic              sa, sb, is_rem, is_word;
  logic [6:0]        cnt;
  logic              accept, flush;

  logic                     op_unsigned, op_word;
  logic signed [DATA_W-1:0] a_ext, b_ext;
  logic                     a_neg, b_neg, div_zero, overflow;
  logic [DATA_W-1:0]        a_mag, b_mag_in;
  logic [DATA_W:0]          shifted, diff;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
    return ~x + 64'd1;
  endfunction

  function automatic logic [DATA_W-1:0] word_ext(input logic [DATA_W-1:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  // Operand preparation: word extraction, sign flags, magnitudes, special cases
  always_comb begin
    op_unsigned = bus.DivOpIn[0];
    op_word     = bus.DivOpIn[2];
    if (op_word) begin
      a_ext = op_unsigned ? {32'h0, bus.Rs1DataIn[31:0]} : word_ext(bus.Rs1DataIn);
      b_ext = op_unsigned ? {32'h0, bus.Rs2DataIn[31:0]} : word_ext(bus.Rs2DataIn);
    end else begin
      a_ext = bus.Rs1DataIn;
      b_ext = bus.Rs2DataIn;
    end
    a_neg    = ~op_unsigned & a_ext[DATA_W-1];
    b_neg    = ~op_unsigned & b_ext[DATA_W-1];
    a_mag    = a_neg ? neg(a_ext) : a_ext;
    b_mag_in = b_neg ? neg(b_ext) : b_ext;
    div_zero = (b_ext == '0);
    overflow = ~op_unsigned & (&b_ext) & (a_ext == (op_word ? MIN_W : MIN_D));
  end

  // One restoring step: shift {rem, quo} and trial-subtract; borrow lands in bit 64
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    diff    = shifted - {1'b0, b_mag};
  end

  // Finalise: apply result signs, pick quotient/remainder, word sign-extension
  always_comb begin
    logic [DATA_W-1:0] q_fin, r_fin, sel;
    q_fin     = (sa ^ sb) ? neg(quo) : quo;
    r_fin     = sa ? neg(rem) : rem;
    sel       = is_rem ? r_fin : q_fin;
    final_val = is_word ? word_ext(sel) : sel;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and handshake outputs; flush wins over everything
  always_comb begin
    state_next                = state;
    accept                    = 1'b0;
    flush                     = bus.DivFlushIn;
    bus.DivReadyOutEx         = 1'b0;
    bus.DivBusyOut            = 1'b0;
    bus.DivResultValidOut     = 1'b0;
    bus.DivResultOut          = result_q;
    case (state)
      IDLE: begin
        bus.DivReadyOutEx = 1'b1;
        bus.DivBusyOut    = bus.DivValidInEx;
        if (!flush && bus.DivValidInEx) begin
          accept     = 1'b1;
          state_next = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        bus.DivBusyOut = 1'b1;
        if (flush)                                     state_next = IDLE;
        else if (cnt == (is_word ? 7'd31 : 7'd63))     state_next = DONE;
      end
      DONE: begin
        bus.DivResultOut      = final_val;
        bus.DivResultValidOut = ~flush;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load at accept, iterate in CALC, capture result on the valid pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      quo      <= '0;
      rem      <= '0;
      b_mag    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      is_rem   <= 1'b0;
      is_word  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        is_rem  <= bus.DivOpIn[1];
        is_word <= op_word;
        cnt     <= '0;
        b_mag   <= b_mag_in;
        if (div_zero) begin
          // Results are already final; signs must not be reapplied
          quo <= '1;
          rem <= a_ext;
          sa  <= 1'b0;
          sb  <= 1'b0;
        end else if (overflow) begin
          quo <= a_ext;
          rem <= '0;
          sa  <= 1'b0;
          sb  <= 1'b0;
        end else begin
          // Word dividends sit in the top half so 32 shifts consume them
          quo <= op_word ? {a_mag[31:0], 32'h0} : a_mag;
          rem <= '0;
          sa  <= a_neg;
          sb  <= b_neg;
        end
      end else if (state == CALC) begin
        cnt <= cnt + 7'd1;
        if (!diff[DATA_W]) begin
          rem <= diff[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b1};
        end else begin
          rem <= shifted[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b0};
        end
      end
      if (bus.DivResultValidOut) result_q <= final_val;
    end
  end
endmodule

// File: tb/tb_ex_divider.sv
// Directed bench for ex_divider: results, latencies, fast paths, flush, reset.
module tb_ex_divider;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  ex_divider_if bus ();

  ex_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request, then watch for the result pulse (bounded wait)
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int k;
    bit seen;
    @(negedge clk);
    bus.DivValidInEx = 1'b1;
    bus.DivOpIn      = op;
    bus.Rs1DataIn    = a;
    bus.Rs2DataIn    = b;
    #1;
    chk({tag, " busy_req"}, 64'(bus.DivBusyOut), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.DivValidInEx = 1'b0;
    k = 1;
    seen = 0;
    while (k <= 100 && !seen) begin
      if (bus.DivResultValidOut) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " result"}, bus.DivResultOut, exp);
    chk({tag, " busy_done"}, 64'(bus.DivBusyOut), 64'd0);
    @(negedge clk);
    chk({tag, " one_pulse"}, 64'(bus.DivResultValidOut), 64'd0);
    chk({tag, " hold"}, bus.DivResultOut, exp);
  endtask

  // Count result pulses over a window; used after aborts
  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.DivResultValidOut) pulses++;
    end
  endtask

  initial begin
    int pulses;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.DivValidInEx = 1'b0;
    bus.DivFlushIn   = 1'b0;
    bus.DivOpIn      = 3'b000;
    bus.Rs1DataIn    = '0;
    bus.Rs2DataIn    = '0;
    repeat (2) @(negedge clk);
    chk("rst result", bus.DivResultOut, 64'd0);
    chk("rst valid", 64'(bus.DivResultValidOut), 64'd0);
    chk("rst ready", 64'(bus.DivReadyOutEx), 64'd1);
    chk("rst busy", 64'(bus.DivBusyOut), 64'd0);
    rst = 1'b1;

    run_op("DIV 100/7",    3'b000, 64'd100, 64'd7, 64'd14, 65);
    run_op("REM 100%7",    3'b010, 64'd100, 64'd7, 64'd2, 65);
    run_op("DIV -7/2",     3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM -7%2",     3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("REMU 7%big",   3'b011, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 65);
    run_op("DIVU 5/0",     3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REMU 5%0",     3'b011, 64'd5, 64'd0, 64'd5, 1);
    run_op("REM -5%0",     3'b010, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
    run_op("DIV ovf",      3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("REM ovf",      3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("DIVW ovf",     3'b100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("DIVUW",        3'b101, 64'h1234_5678_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33);
    run_op("DIVUW ext",    3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("REMW -7%2",    3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Flush in CALC cycle 10
    @(negedge clk);
    bus.DivValidInEx = 1'b1;
    bus.DivOpIn      = 3'b000;
    bus.Rs1DataIn    = 64'd100;
    bus.Rs2DataIn    = 64'd7;
    @(posedge clk);
    @(negedge clk);
    bus.DivValidInEx = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush calc busy", 64'(bus.DivBusyOut), 64'd1);
    bus.DivFlushIn = 1'b1;
    @(negedge clk);
    bus.DivFlushIn = 1'b0;
    chk("flush ready", 64'(bus.DivReadyOutEx), 64'd1);
    count_pulses(70, pulses);
    chk("flush no pulse", 64'(pulses), 64'd0);
    run_op("DIV 9/3", 3'b000, 64'd9, 64'd3, 64'd3, 65);

    // Flush together with a request in IDLE: not accepted
    @(negedge clk);
    bus.DivValidInEx = 1'b1;
    bus.DivFlushIn   = 1'b1;
    bus.DivOpIn      = 3'b001;
    bus.Rs1DataIn    = 64'd5;
    bus.Rs2DataIn    = 64'd0;
    @(negedge clk);
    bus.DivValidInEx = 1'b0;
    bus.DivFlushIn   = 1'b0;
    chk("flush idle ready", 64'(bus.DivReadyOutEx), 64'd1);
    chk("flush idle valid", 64'(bus.DivResultValidOut), 64'd0);

    // Flush while in DONE suppresses the pulse
    bus.DivValidInEx = 1'b1;
    @(negedge clk);
    bus.DivValidInEx = 1'b0;
    bus.DivFlushIn   = 1'b1;
    #1;
    chk("flush done valid", 64'(bus.DivResultValidOut), 64'd0);
    @(negedge clk);
    bus.DivFlushIn = 1'b0;
    chk("flush done ready", 64'(bus.DivReadyOutEx), 64'd1);
    chk("flush done after", 64'(bus.DivResultValidOut), 64'd0);

    // Reset in the middle of CALC
    bus.DivValidInEx = 1'b1;
    bus.DivOpIn      = 3'b000;
    bus.Rs1DataIn    = 64'd100;
    bus.Rs2DataIn    = 64'd7;
    @(negedge clk);
    bus.DivValidInEx = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst result", bus.DivResultOut, 64'd0);
    chk("midrst valid", 64'(bus.DivResultValidOut), 64'd0);
    chk("midrst ready", 64'(bus.DivReadyOutEx), 64'd1);
    chk("midrst busy", 64'(bus.DivBusyOut), 64'd0);
    count_pulses(70, pulses);
    chk("midrst no pulse", 64'(pulses), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
